// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and capacity helper for the synchronous FIFO
package fifo_pkg;

    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    // Total words held: 2^depth in storage plus the one-word output register.
    function automatic int fifo_capacity(input int depth);
        return (1 << depth) + 1;
    endfunction

endpackage

// File: rtl/SyncMem.sv
// rtl/SyncMem.sv - simple dual-port memory with synchronous write and registered read
module SyncMem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             WEN,
    input  logic [DEPTH-1:0] WADDR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             REN,
    input  logic [DEPTH-1:0] RADDR,
    output logic [WIDTH-1:0] DOUT
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    // DOUT is deliberately not reset; it only updates on a read.
    always_ff @(posedge CLK) begin
        if (WEN) begin
            mem[WADDR] <= DIN;
        end
        if (REN) begin
            DOUT <= mem[RADDR];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - valid/ready FIFO whose memory read register doubles as the output stage
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic [DEPTH:0]   COUNT
);

    localparam int             MEM_WORDS = fifo_capacity(DEPTH) - 1;
    localparam logic [DEPTH:0] MEM_FULL  = (DEPTH+1)'(MEM_WORDS);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
    localparam logic [DEPTH:0] CNT_ONE   = (DEPTH+1)'(1);

    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   mem_count;
    logic             enable;
    logic             out_valid;
    logic             push;
    logic             ren;
    logic             pop;

    assign IN_READY = enable && (mem_count < MEM_FULL);
    assign push     = IN_VALID && IN_READY;
    assign pop      = out_valid && OUT_READY;
    // Only committed slots are read, so a read never races the slot being written.
    assign ren      = (mem_count != '0) && (!out_valid || OUT_READY);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            enable    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            enable <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ren) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !ren) begin
                mem_count <= mem_count + CNT_ONE;
            end else if (!push && ren) begin
                mem_count <= mem_count - CNT_ONE;
            end
            if (ren) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign OUT_VALID = out_valid;
    assign COUNT     = mem_count + {{DEPTH{1'b0}}, out_valid};

    SyncMem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .WEN   (push),
        .WADDR (wr_ptr),
        .DIN   (IN_DATA),
        .REN   (ren),
        .RADDR (rd_ptr),
        .DOUT  (OUT_DATA)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized queue-model bench for sync_fifo
module tb_sync_fifo;

    localparam int W = 32;
    localparam int D = 4;
    localparam int MEM_WORDS = 1 << D;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          IN_VALID;
    logic          IN_READY;
    logic [W-1:0]  IN_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [W-1:0]  OUT_DATA;
    logic [D:0]    COUNT;

    int checks   = 0;
    int failures = 0;

    sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .COUNT     (COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: words waiting in storage, plus a separately held head word.
    logic [W-1:0] m_store[$];
    logic [W-1:0] m_head = '0;
    bit           m_hv   = 0;
    bit           m_en   = 0;

    initial begin
        forever begin
            @(posedge CLK or negedge RESETn);
            if (!RESETn) begin
                m_store.delete();
                m_hv = 0;
                m_en = 0;
            end else begin
                bit take_in;
                bit refill;
                take_in = IN_VALID && m_en && (m_store.size() < MEM_WORDS);
                refill  = (m_store.size() > 0) && (!m_hv || OUT_READY);
                if (refill) begin
                    m_head = m_store.pop_front();
                    m_hv   = 1;
                end else if (m_hv && OUT_READY) begin
                    m_hv = 0;
                end
                if (take_in) m_store.push_back(IN_DATA);
                m_en = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            check("in_ready", 64'(IN_READY), 64'(m_en && (m_store.size() < MEM_WORDS)));
            check("out_valid", 64'(OUT_VALID), 64'(m_hv));
            check("count", 64'(COUNT), 64'(m_store.size() + int'(m_hv)));
            if (m_hv) check("out_data", 64'(OUT_DATA), 64'(m_head));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int accepted;
    int ins;
    int outs;
    logic [W-1:0] pop17;

    initial begin
        RESETn    = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        tick();
        tick();
        check("reset_in_ready", 64'(IN_READY), 64'd0);
        check("reset_count", 64'(COUNT), 64'd0);
        check("reset_out_valid", 64'(OUT_VALID), 64'd0);
        RESETn = 1'b1;
        #1;
        check("release_in_ready_low", 64'(IN_READY), 64'd0);
        tick();
        check("release_in_ready_high", 64'(IN_READY), 64'd1);

        // Fall-through: three back-to-back words.
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        IN_DATA   = 32'h11;
        tick();
        check("ft_valid_t1", 64'(OUT_VALID), 64'd0);
        IN_DATA = 32'h22;
        tick();
        check("ft_valid_t2", 64'(OUT_VALID), 64'd1);
        check("ft_data0", 64'(OUT_DATA), 64'h11);
        IN_DATA = 32'h33;
        tick();
        check("ft_data1", 64'(OUT_DATA), 64'h22);
        IN_VALID = 1'b0;
        tick();
        check("ft_data2", 64'(OUT_DATA), 64'h33);
        tick();
        check("ft_drained", 64'(OUT_VALID), 64'd0);

        // Fill: capacity is 2^D + 1.
        OUT_READY = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 20; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = W'(i);
            if (IN_READY) accepted++;
            tick();
        end
        IN_VALID = 1'b0;
        check("fill_accepted", 64'(accepted), 64'd17);
        check("fill_count", 64'(COUNT), 64'd17);
        check("fill_in_ready", 64'(IN_READY), 64'd0);
        check("fill_head", 64'(OUT_DATA), 64'd0);

        // Streaming through a full FIFO across pointer wrap.
        ins  = 0;
        outs = 0;
        pop17 = '0;
        for (int i = 0; i < 40; i++) begin
            IN_VALID  = 1'b1;
            OUT_READY = 1'b1;
            IN_DATA   = W'(100 + ins);
            if (OUT_VALID) begin
                if (outs == 17) pop17 = OUT_DATA;
                outs++;
            end
            if (IN_READY) ins++;
            tick();
        end
        IN_VALID = 1'b0;
        check("stream_outs", 64'(outs), 64'd40);
        check("stream_ins", 64'(ins), 64'd39);
        check("stream_pop17", 64'(pop17), 64'd100);
        for (int i = 0; i < 40 && COUNT != 0; i++) tick();
        check("stream_drained", 64'(COUNT), 64'd0);

        // Pops from empty have no effect.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_valid", 64'(OUT_VALID), 64'd0);
            check("empty_count", 64'(COUNT), 64'd0);
        end

        // Reset mid-operation.
        OUT_READY = 1'b0;
        for (int i = 0; i < 9; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = W'(200 + i);
            tick();
        end
        IN_VALID = 1'b0;
        check("pre_reset_count", 64'(COUNT), 64'd9);
        #2;
        RESETn = 1'b0;
        #1;
        check("mid_reset_count", 64'(COUNT), 64'd0);
        check("mid_reset_valid", 64'(OUT_VALID), 64'd0);
        check("mid_reset_in_ready", 64'(IN_READY), 64'd0);
        tick();
        tick();
        RESETn = 1'b1;
        #1;
        check("post_reset_in_ready_low", 64'(IN_READY), 64'd0);
        tick();
        check("post_reset_in_ready_high", 64'(IN_READY), 64'd1);
        IN_VALID  = 1'b1;
        IN_DATA   = 32'hAB;
        tick();
        IN_VALID  = 1'b0;
        for (int i = 0; i < 10 && !OUT_VALID; i++) tick();
        check("post_reset_first_valid", 64'(OUT_VALID), 64'd1);
        check("post_reset_first_word", 64'(OUT_DATA), 64'hAB);
        OUT_READY = 1'b1;
        tick();

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = 1'($urandom_range(0, 1));
            IN_DATA   = $urandom;
            tick();
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 40 && COUNT != 0; i++) tick();
        check("random_drained", 64'(COUNT), 64'd0);
        check("random_model_empty", 64'(m_store.size() + int'(m_hv)), 64'd0);

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
